// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register family.
//   - Frame FSM state encoding (ST_IDLE / ST_SHIFT / ST_PAR) and its typed enum.
//   - Serial bit-order encoding (DIR_MSB_FIRST / DIR_LSB_FIRST), shared with the
//     transmitter's mode decode.
package shift_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StPar   = ST_PAR
  } deser_state_e;

endpackage

// File: rtl/shift_deser_outbuf.sv
// Output buffer of the serial deserializer.
// Holds the last delivered word with a valid/ack handshake, a sticky overflow
// flag and (with SHIFT_DESER_PARITY_EN) a parity-error flag. q_o is tri-stated
// by oe_i; all flags are always driven.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       completed word available this edge
//   din_i        completed word
//   pin_i        received parity bit (only meaningful with the parity feature)
//   ack_i        consumer accepts the buffered word
//   clr_i        clears the overflow flag
//   oe_i         1 = drive q_o, 0 = high-Z
//   q_o          buffered word, tri-state
//   valid_o      q_o holds an unconsumed word
//   ovf_o        sticky overflow flag
//   perr_o       parity error of the buffered word (0 without the feature)
module shift_deser_outbuf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pin_i,
  input  logic             ack_i,
  input  logic             clr_i,
  input  logic             oe_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             perr_o
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             accept;

  // A new word is taken if the buffer is empty or being drained on this edge.
  assign accept = load_i && (!valid_q || ack_i);

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (load_i) begin
      if (accept) begin
        out_d   = din_i;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ack_i) begin
      valid_d = 1'b0;
    end
    if (clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SHIFT_DESER_PARITY_EN
  logic perr_q;

  // Even parity: data XOR parity bit must be 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else if (accept) begin
      perr_q <= (^din_i) ^ pin_i;
    end
  end

  assign perr_o = perr_q;
`else
  logic unused_pin;
  assign unused_pin = pin_i;
  assign perr_o     = 1'b0;
`endif

  assign q_o     = oe_i ? out_q : {WIDTH{1'bz}};
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in / parallel-out receiver for the universal shift register link.
// Reassembles WIDTH serial bits (MSB or LSB first, chosen per frame by dir_i at
// the first bit) into a word delivered to a valid/ack output buffer.
// Optional feature macro: SHIFT_DESER_PARITY_EN adds an even-parity bit after
// the data bits and drives perr_o; without it perr_o is constant 0.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en_i         serial bit strobe
//   sin_i        serial data bit
//   dir_i        bit order: 0 = MSB first, 1 = LSB first
//   clr_i        synchronous abort of the partial frame, clears ovf_o
//   ack_i        consumer accepts the buffered word
//   oe_i         output enable for q_o
//   q_o          received word, tri-state
//   valid_o      q_o holds an unconsumed word
//   busy_o       frame in progress
//   ovf_o        sticky overflow flag
//   perr_o       parity error for the buffered word
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sin_i,
  input  logic             dir_i,
  input  logic             clr_i,
  input  logic             ack_i,
  input  logic             oe_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             perr_o
);

  deser_state_e     state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_dir_q, frame_dir_d;

  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shifted;
  logic             dir_sel;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic             load_par;

  // The first bit of a frame uses the live dir_i and shifts into a clean register.
  always_comb begin
    shift_base = (state_q == StIdle) ? '0 : sr_q;
    dir_sel    = (state_q == StIdle) ? dir_i : frame_dir_q;
    if (dir_sel == DIR_LSB_FIRST) begin
      shifted = {sin_i, shift_base[WIDTH-1:1]};
    end else begin
      shifted = {shift_base[WIDTH-2:0], sin_i};
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    frame_dir_d = frame_dir_q;
    load        = 1'b0;
    load_word   = shifted;
    load_par    = 1'b0;
    if (clr_i) begin
      state_d = StIdle;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en_i) begin
            sr_d        = shifted;
            cnt_d       = CW'(1);
            frame_dir_d = dir_i;
            state_d     = StShift;
          end
        end
        StShift: begin
          if (en_i) begin
            sr_d = shifted;
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_d = '0;
`ifdef SHIFT_DESER_PARITY_EN
              state_d = StPar;
`else
              load    = 1'b1;
              state_d = StIdle;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
`ifdef SHIFT_DESER_PARITY_EN
        StPar: begin
          if (en_i) begin
            load      = 1'b1;
            load_word = sr_q;
            load_par  = sin_i;
            state_d   = StIdle;
          end
        end
`endif
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= '0;
      frame_dir_q <= DIR_MSB_FIRST;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      frame_dir_q <= frame_dir_d;
    end
  end

  assign busy_o = (state_q != StIdle);

  shift_deser_outbuf #(
    .WIDTH(WIDTH)
  ) u_outbuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .din_i  (load_word),
    .pin_i  (load_par),
    .ack_i  (ack_i),
    .clr_i  (clr_i),
    .oe_i   (oe_i),
    .q_o    (q_o),
    .valid_o(valid_o),
    .ovf_o  (ovf_o),
    .perr_o (perr_o)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer (WIDTH = 4), scoreboard style.
module tb_shift_deserializer;

  localparam int unsigned W = 4;
`ifdef SHIFT_DESER_PARITY_EN
  localparam bit HasPar = 1'b1;
`else
  localparam bit HasPar = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, sin, dir, clr, ack, oe;
  wire  [W-1:0] q;
  logic         valid, busy, ovf, perr;

  shift_deserializer #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .sin_i  (sin),
    .dir_i  (dir),
    .clr_i  (clr),
    .ack_i  (ack),
    .oe_i   (oe),
    .q_o    (q),
    .valid_o(valid),
    .busy_o (busy),
    .ovf_o  (ovf),
    .perr_o (perr)
  );

  always #5 clk = ~clk;

  // Scoreboard entries: {perr, word}
  logic [W:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  // Reference model of the output buffer
  logic         exp_valid, exp_ovf, exp_perr;
  logic [W-1:0] exp_q;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after the rising edge.
  task automatic tick(input logic e, input logic s, input logic a, input logic c);
    @(negedge clk);
    en = e; sin = s; ack = a; clr = c;
    @(posedge clk);
    #1;
    en = 1'b0; ack = 1'b0; clr = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(valid), 32'(exp_valid));
    check_eq({tag, "_ovf"},   32'(ovf),   32'(exp_ovf));
    check_eq({tag, "_q"},     32'(q),     32'(exp_q));
  endtask

  task automatic do_ack();
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    exp_valid = 1'b0;
    check_outputs("ack");
  endtask

  // Book an expected delivery (or overflow) before the final edge is driven.
  task automatic expect_delivery(input logic [W-1:0] data, input logic pbit, input logic ack_last,
                                 output logic will_load);
    logic pe;
    pe = HasPar ? ((^data) ^ pbit) : 1'b0;
    will_load = !exp_valid || ack_last;
    if (will_load) sb_q.push_back({pe, data});
  endtask

  task automatic finish_delivery(input string tag, input logic will_load);
    logic [W:0] e;
    if (will_load) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_sb: got empty scoreboard expected entry", tag);
      end else begin
        e        = sb_q.pop_front();
        exp_q    = e[W-1:0];
        exp_perr = e[W];
      end
    end else begin
      exp_ovf = 1'b1;
    end
    exp_valid = 1'b1;
    check_outputs(tag);
    check_eq({tag, "_perr"}, 32'(perr), 32'(exp_perr));
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic send_frame(input string tag, input logic [W-1:0] data, input logic d,
                            input logic pbit, input logic ack_last);
    logic wl;
    logic b;
    expect_delivery(data, pbit, ack_last, wl);
    dir = d;
    for (int i = 0; i < int'(W); i++) begin
      b = d ? data[i] : data[W-1-i];
      if (i == int'(W) - 1) check_eq({tag, "_pre_valid"}, 32'(valid), 32'(exp_valid));
      tick(1'b1, b, (!HasPar && i == int'(W) - 1) ? ack_last : 1'b0, 1'b0);
      if (i == 0) check_eq({tag, "_busy1"}, 32'(busy), 32'd1);
    end
    if (HasPar) tick(1'b1, pbit, ack_last, 1'b0);
    finish_delivery(tag, wl);
  endtask

  initial begin
    logic wl;
    rst_n = 1'b0;
    en = 1'b0; sin = 1'b0; dir = 1'b0; clr = 1'b0; ack = 1'b0; oe = 1'b1;
    exp_valid = 1'b0; exp_ovf = 1'b0; exp_perr = 1'b0; exp_q = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_perr", 32'(perr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MSB-first frame 1011
    send_frame("f1011", 4'b1011, 1'b0, 1'b1, 1'b0);
    do_ack();

    // LSB-first 1,1,0,0 with dir flipped mid-frame -> 0011
    expect_delivery(4'b0011, 1'b0, 1'b0, wl);
    dir = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    dir = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    if (HasPar) tick(1'b1, 1'b0, 1'b0, 1'b0);
    finish_delivery("f0011", wl);
    do_ack();

    // Overflow: second word dropped, clr clears ovf only
    send_frame("f1010", 4'b1010, 1'b0, 1'b0, 1'b0);
    send_frame("drop", 4'b0101, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    exp_ovf = 1'b0;
    check_outputs("clr");

    // Completion coincident with ack loads the new word
    send_frame("ackload", 4'b0101, 1'b0, 1'b0, 1'b1);
    do_ack();

    // Partial frame aborted by clr (with en on the same edge)
    dir = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    send_frame("f0110", 4'b0110, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame while a word is buffered
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_valid = 1'b0; exp_ovf = 1'b0; exp_perr = 1'b0; exp_q = '0;
    check_outputs("midrst");
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_perr", 32'(perr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // High-Z bus while a word is valid
    send_frame("hiz_frame", 4'b0110, 1'b1, 1'b0, 1'b0);
    oe = 1'b0;
    #1;
    check_eq("hiz_q_released", 32'(q === exp_q), 32'd0);
    check_eq("hiz_valid", 32'(valid), 32'd1);
    oe = 1'b1;
    #1;
    check_eq("oe_q", 32'(q), 32'(exp_q));
    do_ack();

    // Parity error detection (with the optional feature this yields perr=1)
    send_frame("par_ok", 4'b1011, 1'b0, 1'b1, 1'b0);
    do_ack();
    send_frame("par_bad", 4'b1011, 1'b0, 1'b0, 1'b0);
    do_ack();

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
